// File: rtl/proyecto_final_fase2.sv
// Single-cycle 32-bit MIPS-subset processor (final project, phase 2).
// Optional feature: define PFF2_JUMP_EN to decode the j instruction (op 02).

module inst_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    logic [31:0] INS [0:DEPTH-1];

    // Program load port; contents are normally preloaded from outside.
    always_ff @(posedge clk) begin
        if (load_en) begin
            INS[load_addr] <= load_data;
        end
    end

    assign data = INS[addr];
endmodule

module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] REG [0:31];

    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            REG[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : REG[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : REG[ra2];
endmodule

module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] RAM [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            RAM[addr] <= wdata;
        end
    end

    assign rdata = RAM[addr];
endmodule

module proyecto_final_fase2 #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] alu_o
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_SLT = 6'h2A
    } funct_e;

    logic [31:0]   pc_q;
    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;
    logic [31:0]   pc_next;
    logic [IW-1:0] imem_addr;
    logic [31:0]   instr;

    opcode_e       op;
    funct_e        funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [31:0]   simm;

    logic [31:0]   rs_val;
    logic [31:0]   rt_val;
    logic [31:0]   alu;
    logic [31:0]   mem_rdata;
    logic [31:0]   wb_data;
    logic [4:0]    wa;
    logic          reg_we_c;
    logic          mem_we_c;
    logic          reg_we;
    logic          mem_we;
    logic          wb_from_mem;
    logic          branch_taken;
`ifdef PFF2_JUMP_EN
    logic          jump;
    logic [31:0]   j_target;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign imem_addr = pc_q[IW+1:2];

    inst_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IW)
    ) MemInst (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_data ('0),
        .addr      (imem_addr),
        .data      (instr)
    );

    assign op    = opcode_e'(instr[31:26]);
    assign funct = funct_e'(instr[5:0]);
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign simm  = {{16{instr[15]}}, instr[15:0]};

    reg_file Register (
        .clk (clk),
        .we  (reg_we),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (wb_data),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    // Decode and execute; anything not listed falls through as a NOP.
    always_comb begin
        alu          = '0;
        reg_we_c     = 1'b0;
        mem_we_c     = 1'b0;
        wb_from_mem  = 1'b0;
        wa           = rd;
        branch_taken = 1'b0;
`ifdef PFF2_JUMP_EN
        jump         = 1'b0;
`endif
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD: begin
                        alu      = rs_val + rt_val;
                        reg_we_c = 1'b1;
                    end
                    F_SUB: begin
                        alu      = rs_val - rt_val;
                        reg_we_c = 1'b1;
                    end
                    F_AND: begin
                        alu      = rs_val & rt_val;
                        reg_we_c = 1'b1;
                    end
                    F_OR: begin
                        alu      = rs_val | rt_val;
                        reg_we_c = 1'b1;
                    end
                    F_SLT: begin
                        alu      = {31'b0, $signed(rs_val) < $signed(rt_val)};
                        reg_we_c = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                alu      = rs_val + simm;
                reg_we_c = 1'b1;
                wa       = rt;
            end
            OP_LW: begin
                alu         = rs_val + simm;
                reg_we_c    = 1'b1;
                wa          = rt;
                wb_from_mem = 1'b1;
            end
            OP_SW: begin
                alu      = rs_val + simm;
                mem_we_c = 1'b1;
            end
            OP_BEQ: begin
                alu          = rs_val - rt_val;
                branch_taken = (rs_val == rt_val);
            end
`ifdef PFF2_JUMP_EN
            OP_J: begin
                jump = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Architectural writes are held off while reset is asserted.
    assign reg_we  = reg_we_c & rst_n;
    assign mem_we  = mem_we_c & rst_n;
    assign wb_data = wb_from_mem ? mem_rdata : alu;

    data_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DW)
    ) Mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu[DW+1:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {simm[29:0], 2'b00};
`ifdef PFF2_JUMP_EN
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
`endif

    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = br_target;
        end
`ifdef PFF2_JUMP_EN
        if (jump) begin
            pc_next = j_target;
        end
`endif
    end

    assign pc_o    = pc_q;
    assign instr_o = instr;
    assign alu_o   = alu;
endmodule

// File: tb/tb_proyecto_final_fase2.sv
// Bench for proyecto_final_fase2: an instruction-level reference model feeds a
// scoreboard of pc/instr/alu per cycle, plus fixed-value architectural checks.

module tb_proyecto_final_fase2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] alu_o;

    proyecto_final_fase2 #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256),
        .RESET_PC   (32'h0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_o    (pc_o),
        .instr_o (instr_o),
        .alu_o   (alu_o)
    );

    always #5 clk = ~clk;

`ifdef PFF2_JUMP_EN
    localparam logic [31:0] JEXP = 32'h0000_0100;
`else
    localparam logic [31:0] JEXP = 32'h0000_0024;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_ins [256];
    logic [31:0] m_ram [256];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put_ins(input logic [7:0] idx, input logic [31:0] w);
        dut.MemInst.INS[idx] = w;
        m_ins[idx] = w;
    endtask

    task automatic put_ram(input logic [7:0] idx, input logic [31:0] w);
        dut.Mem.RAM[idx] = w;
        m_ram[idx] = w;
    endtask

    task automatic put_reg(input logic [4:0] r, input logic [31:0] w);
        dut.Register.REG[r] = w;
        m_reg[r] = w;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) put_ins(8'(i), 32'h0);
    endtask

    // Reference model: executes one instruction, returns the expected alu_o.
    task automatic model_step(output logic [31:0] alu_e);
        logic [31:0] ins, a, b, simm, npc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        ins  = m_ins[m_pc[9:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        a    = (rs == 5'd0) ? 32'h0 : m_reg[rs];
        b    = (rt == 5'd0) ? 32'h0 : m_reg[rt];
        npc  = m_pc + 32'd4;
        alu_e = 32'h0;
        if (op == 6'h00) begin
            if (fn == 6'h20) alu_e = a + b;
            else if (fn == 6'h22) alu_e = a - b;
            else if (fn == 6'h24) alu_e = a & b;
            else if (fn == 6'h25) alu_e = a | b;
            else if (fn == 6'h2A) alu_e = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            if ((fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                && rd != 5'd0) m_reg[rd] = alu_e;
        end else if (op == 6'h08) begin
            alu_e = a + simm;
            if (rt != 5'd0) m_reg[rt] = alu_e;
        end else if (op == 6'h23) begin
            alu_e = a + simm;
            if (rt != 5'd0) m_reg[rt] = m_ram[alu_e[9:2]];
        end else if (op == 6'h2B) begin
            alu_e = a + simm;
            m_ram[alu_e[9:2]] = b;
        end else if (op == 6'h04) begin
            alu_e = a - b;
            if (a == b) npc = npc + (simm << 2);
        end
`ifdef PFF2_JUMP_EN
        else if (op == 6'h02) begin
            npc = {npc[31:28], ins[25:0], 2'b00};
        end
`endif
        m_pc = npc;
    endtask

    // Entered and left on a falling edge with DUT and model in the same state.
    task automatic run_cycles(input int unsigned n);
        exp_t        e;
        logic [31:0] a;
        for (int unsigned k = 0; k < n; k++) begin
            e.pc    = m_pc;
            e.instr = m_ins[m_pc[9:2]];
            model_step(a);
            e.alu   = a;
            exp_q.push_back(e);
            #1;
            e = exp_q.pop_front();
            chk("pc", pc_o, e.pc);
            chk("instr", instr_o, e.instr);
            chk("alu", alu_o, e.alu);
            @(negedge clk);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_pc  = 32'h0;
        exp_q.delete();
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        m_pc = 32'h0;
        for (int i = 0; i < 256; i++) begin
            put_ins(8'(i), 32'h0);
            put_ram(8'(i), 32'hA5A5_0000 | 32'(i));
        end
        for (int r = 0; r < 32; r++) put_reg(5'(r), 32'h0);

        // Reset holds PC and suppresses writes.
        put_reg(5'd1, 32'h77);
        put_ins(8'd0, enc_i(6'h08, 5'd0, 5'd1, 16'h0055));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h2001_0055);
        chk("rst_reg1", dut.Register.REG[1], 32'h77);
        put_ins(8'd0, enc_i(6'h2B, 5'd0, 5'd1, 16'h0000));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram0", dut.Mem.RAM[0], 32'hA5A5_0000);
        leave_reset();
        run_cycles(1);
        chk("rel_pc", pc_o, 32'h4);
        chk("rel_ram0", dut.Mem.RAM[0], 32'h77);

        // ALU group.
        enter_reset();
        clear_prog();
        put_reg(5'd1, 32'd5);
        put_reg(5'd2, 32'd3);
        put_reg(5'd10, 32'h0);
        put_ins(8'd0, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put_ins(8'd1, enc_r(5'd1, 5'd2, 5'd4, 6'h22));
        put_ins(8'd2, enc_r(5'd1, 5'd2, 5'd5, 6'h24));
        put_ins(8'd3, enc_r(5'd1, 5'd2, 5'd6, 6'h25));
        put_ins(8'd4, enc_r(5'd2, 5'd1, 5'd7, 6'h2A));
        put_ins(8'd5, enc_i(6'h08, 5'd0, 5'd8, 16'hFFFF));
        put_ins(8'd6, enc_r(5'd8, 5'd0, 5'd9, 6'h2A));
        put_ins(8'd7, 32'h0000_0000);
        put_ins(8'd8, 32'hFC00_0000);
        put_ins(8'd9, enc_r(5'd1, 5'd2, 5'd10, 6'h21));
        leave_reset();
        run_cycles(10);
        chk("add_r3", dut.Register.REG[3], 32'd8);
        chk("sub_r4", dut.Register.REG[4], 32'd2);
        chk("and_r5", dut.Register.REG[5], 32'd1);
        chk("or_r6", dut.Register.REG[6], 32'd7);
        chk("slt_r7", dut.Register.REG[7], 32'd1);
        chk("addi_r8", dut.Register.REG[8], 32'hFFFF_FFFF);
        chk("slt_r9", dut.Register.REG[9], 32'd1);
        chk("nop_r10", dut.Register.REG[10], 32'd0);

        // Memory group, including address wrap and ignored low bits.
        enter_reset();
        clear_prog();
        put_reg(5'd1, 32'd8);
        put_reg(5'd2, 32'hDEAD_BEEF);
        put_ins(8'd0, enc_i(6'h2B, 5'd1, 5'd2, 16'd4));
        put_ins(8'd1, enc_i(6'h23, 5'd1, 5'd3, 16'd4));
        put_ins(8'd2, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        put_ins(8'd3, enc_i(6'h08, 5'd0, 5'd5, 16'h0400));
        put_ins(8'd4, enc_i(6'h2B, 5'd5, 5'd5, 16'h0010));
        put_ins(8'd5, enc_i(6'h23, 5'd0, 5'd6, 16'h0013));
        put_ins(8'd6, enc_r(5'd0, 5'd3, 5'd7, 6'h20));
        leave_reset();
        run_cycles(7);
        chk("sw_ram3", dut.Mem.RAM[3], 32'hDEAD_BEEF);
        chk("lw_r3", dut.Register.REG[3], 32'hDEAD_BEEF);
        chk("r0_zero", dut.Register.REG[0], 32'h0);
        chk("wrap_ram4", dut.Mem.RAM[4], 32'h400);
        chk("lw_r6", dut.Register.REG[6], 32'h400);
        chk("fwd_r7", dut.Register.REG[7], 32'hDEAD_BEEF);

        // Branch and jump.
        enter_reset();
        clear_prog();
        put_reg(5'd1, 32'd1);
        put_reg(5'd2, 32'd2);
        put_ins(8'd4, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put_ins(8'd7, enc_i(6'h04, 5'd1, 5'd2, 16'd2));
        put_ins(8'd8, {6'h02, 26'h40});
        put_ins(8'd9, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        put_ins(8'd64, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        leave_reset();
        run_cycles(5);
        chk("beq_taken", pc_o, 32'h1C);
        run_cycles(1);
        chk("beq_fall", pc_o, 32'h20);
        run_cycles(1);
        chk("jump", pc_o, JEXP);
        run_cycles(3);
        chk("beq_loop", pc_o, JEXP);

        // Asynchronous reset mid-program.
        enter_reset();
        clear_prog();
        put_reg(5'd10, 32'h0);
        put_ins(8'd0, enc_i(6'h08, 5'd10, 5'd10, 16'd1));
        leave_reset();
        run_cycles(12);
        chk("pre_rst_pc", pc_o, 32'h30);
        #2;
        rst_n = 1'b0;
        m_pc  = 32'h0;
        #1;
        chk("async_pc", pc_o, 32'h0);
        chk("async_instr", instr_o, 32'h214A_0001);
        chk("keep_r10", dut.Register.REG[10], 32'd1);
        leave_reset();
        run_cycles(2);
        chk("resume_r10", dut.Register.REG[10], 32'd2);
        chk("resume_pc", pc_o, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
